sprite_rom_responder: RTL
=========================

// Module: sprite_rom_responder
// PURPOSE
//  Memory-side responder for the sprite address generators. Accepts per-pixel sprite ROM
//  address requests from the player and enemy address generators and arbitrates them onto
//  one synchronous sprite ROM port. Returns a palette index with an opaque flag, aligned to
//  a delayed DrawX/DrawY tag, so the colour mapper can composite without its own pipeline.
// PARAMETERS
//  ADDR_W        16     ROM address width (word addresses)
//  ROM_DEPTH     41472  valid words; right-facing set at 0, left-facing set at 20736
//  PIX_W         5      palette index width
//  TRANSP_KEY    0      palette index treated as transparent
// PORTS
//  frame_Clk     in   1       clock
//  Reset         in   1       synchronous, active-high reset
//  player_req    in   1       player pixel request (player on-sprite flag)
//  player_addr   in   32      player sprite word address
//  enemy_req     in   1       enemy pixel request
//  enemy_addr    in   32      enemy sprite word address
//  DrawX, DrawY  in   10 each current pixel coordinate (tag)
//  frame_start   in   1       one-cycle pulse at start of frame
//  rom_addr      out  ADDR_W  ROM address
//  rom_en        out  1       ROM read enable
//  rom_data      in   PIX_W   ROM read data, valid one edge after rom_addr/rom_en
//  pix_valid     out  1       response valid
//  pix_index     out  PIX_W   returned palette index (TRANSP_KEY when not opaque)
//  pix_opaque    out  1       index != TRANSP_KEY and request was in range
//  pix_src       out  1       0=player, 1=enemy
//  pix_x, pix_y  out  10 each DrawX/DrawY delayed to match the response
//  drop_count    out  16      enemy requests lost to the player this frame
// BEHAVIOUR
//  - Reset: all outputs 0; pipeline valid bits cleared; drop_count 0.
//  - S0, edge k: arbitrate. player_req wins over enemy_req. Register rom_addr = winner addr[ADDR_W-1:0],
//    rom_en=1, and the tag {src, in_range, DrawX, DrawY}. With no request, rom_en=0 and the valid bit is 0.
//  - in_range = (addr < ROM_DEPTH), using the full 32 bits. An out-of-range request still issues
//    (rom_en=0, rom_addr=0) and its response is forced to transparent.
//  - S1, edge k+1: ROM registers its data; the tag shifts forward one stage.
//  - S2, edge k+2: capture pix_index = in_range ? rom_data : TRANSP_KEY; pix_opaque = in_range &&
//    rom_data != TRANSP_KEY; pix_valid=1. Fixed latency 2 edges; one request accepted every cycle
//    with no stall and no backpressure.
//  - Both req high: player served. drop_count increments with saturation at 16'hFFFF. No replay.
//  - frame_start: drop_count clears to 0. If frame_start and a drop coincide, drop_count = 1.
//  - Reset mid-pipeline: in-flight responses are discarded; no pix_valid on the following 2 edges
//    unless new requests arrive.
//  - pix_* hold their last values when pix_valid=0. Consumers qualify on pix_valid.
// STRUCTURE
//  - Shared package sprite_pkg: ADDR_W, PIX_W, ROM_DEPTH, RIGHT_OFFSET=0, LEFT_OFFSET=20736,
//    TRANSP_KEY, and typedef pix_tag_t {src, in_range, x[9:0], y[9:0]}.
//  - Sub-module sprite_req_arbiter: combinational priority select plus drop detect.
//    The pipeline registers and counter live in the top module.
//  - ROM instance stays outside this block.
// TESTING
//  1 Reset held 3 edges with requests active -> pix_valid=0, drop_count=0, rom_en=0.
//  2 player_req, addr=100, ROM[100]=7, DrawX=50 -> two edges later: pix_valid=1, index=7,
//    opaque=1, src=0, pix_x=50.
//  3 player_req + enemy_req same cycle (addrs 5, 20741) -> only player served, drop_count=1;
//    next cycle enemy alone, addr 20741 -> src=1.
//  4 player addr=41472 (out of range) -> index=0, opaque=0, pix_valid=1, rom_en=0.
//  5 back-to-back requests on 8 consecutive cycles, addrs 0..7 -> 8 consecutive valid responses,
//    in order, no bubbles.
//  6 600 forced conflicts, then frame_start -> drop_count 600 then 0.
//    Conflict on the same edge as frame_start -> 1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite ROM constants and the response tag that travels alongside a ROM read.
package sprite_pkg;
  localparam int ADDR_W       = 16;
  localparam int PIX_W        = 5;
  localparam int ROM_DEPTH    = 41472;
  localparam int RIGHT_OFFSET = 0;
  localparam int LEFT_OFFSET  = 20736;
  localparam int STAGES       = 2;
  localparam logic [PIX_W-1:0] TRANSP_KEY = '0;

  typedef struct packed {
    logic       src;
    logic       in_range;
    logic [9:0] x;
    logic [9:0] y;
  } pix_tag_t;
endpackage

// File: rtl/sprite_req_arbiter.sv
// Fixed-priority select between player and enemy requests; flags enemy requests lost to the player.
module sprite_req_arbiter (
  input  logic        player_req,
  input  logic [31:0] player_addr,
  input  logic        enemy_req,
  input  logic [31:0] enemy_addr,
  output logic        req,
  output logic        src,
  output logic [31:0] addr,
  output logic        drop
);
  always_comb begin
    req  = player_req | enemy_req;
    src  = ~player_req & enemy_req;
    addr = player_req ? player_addr : enemy_addr;
    drop = player_req & enemy_req;
  end
endmodule

// File: rtl/sprite_rom_responder.sv
// Arbitrates sprite pixel requests onto one ROM port and returns a tagged palette index two edges later.
module sprite_rom_responder
  import sprite_pkg::*;
(
  input  logic              frame_Clk,
  input  logic              Reset,
  input  logic              player_req,
  input  logic [31:0]       player_addr,
  input  logic              enemy_req,
  input  logic [31:0]       enemy_addr,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_index,
  output logic              pix_opaque,
  output logic              pix_src,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [15:0]       drop_count
);
  logic        req, src, drop, in_range;
  logic [31:0] sel_addr;

  sprite_req_arbiter u_arb (
    .player_req  (player_req),
    .player_addr (player_addr),
    .enemy_req   (enemy_req),
    .enemy_addr  (enemy_addr),
    .req         (req),
    .src         (src),
    .addr        (sel_addr),
    .drop        (drop)
  );

  // Range check on the full 32 bits so high garbage bits cannot alias into the ROM.
  assign in_range = sel_addr < 32'(ROM_DEPTH);

  // vld_pipe[0]: issued to ROM, [1]: ROM data registered, [2]: response captured.
  logic [STAGES:0] vld_pipe;
  pix_tag_t        tag_pipe [STAGES];

  assign pix_valid = vld_pipe[STAGES];

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      vld_pipe    <= '0;
      tag_pipe[0] <= '0;
      tag_pipe[1] <= '0;
      rom_addr    <= '0;
      rom_en      <= 1'b0;
      pix_index   <= '0;
      pix_opaque  <= 1'b0;
      pix_src     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      drop_count  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], req};
      rom_en   <= req & in_range;
      if (req) begin
        rom_addr    <= in_range ? sel_addr[ADDR_W-1:0] : '0;
        tag_pipe[0] <= '{src: src, in_range: in_range, x: DrawX, y: DrawY};
      end
      tag_pipe[1] <= tag_pipe[0];

      if (vld_pipe[1]) begin
        pix_index  <= tag_pipe[1].in_range ? rom_data : TRANSP_KEY;
        pix_opaque <= tag_pipe[1].in_range && (rom_data != TRANSP_KEY);
        pix_src    <= tag_pipe[1].src;
        pix_x      <= tag_pipe[1].x;
        pix_y      <= tag_pipe[1].y;
      end

      // A drop on the frame_start edge counts as the first drop of the new frame.
      if (frame_start)
        drop_count <= {15'd0, drop};
      else if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
endmodule
